sv32_ptw: RTL and testbench
===========================

# sv32_ptw

Sv32 hardware page-table walker shared by the ITLB and DTLB miss paths in the MMS subsystem. The block arbitrates round-robin between the two TLB miss requesters, performs the one- or two-level Sv32 walk over a single-outstanding memory read port, and returns either a refill PTE or a fault to the requesting TLB. It contains no TLB storage; the TLBs install the returned entry.

## Interface
- `VADDR_WD`, 32, virtual address width (Sv32).
- `PADDR_WD`, 34, physical address width.
- `PTE_WD`, 32, page-table entry width.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `satp_ppn_i`  in  22  root page-table PPN.
- `flush_i`  in  1  abort the walk in progress (TLB/ASID flush).
- `itlb_req_i`  in  1  ITLB miss request, held until granted.
- `itlb_vaddr_i`  in  VADDR_WD  ITLB miss address.
- `itlb_gnt_o`  out  1  one-cycle accept pulse to ITLB.
- `dtlb_req_i`, `dtlb_vaddr_i`, `dtlb_gnt_o`: same as ITLB, for DTLB.
- `mem_req_o`  out  1  PTE read request.
- `mem_addr_o`  out  PADDR_WD  PTE address; word-aligned.
- `mem_gnt_i`  in  1  memory accepts the request.
- `mem_rvalid_i`  in  1  read data valid.
- `mem_rdata_i`  in  PTE_WD  PTE read data.
- `mem_err_i`  in  1  bus error, qualified by `mem_rvalid_i`.
- `resp_valid_o`  out  1  one-cycle response pulse.
- `resp_dst_o`  out  1  0 = ITLB, 1 = DTLB.
- `resp_vpn_o`  out  20  {vpn1, vpn0} of the walked address.
- `resp_pte_o`  out  PTE_WD  leaf PTE; 0 on fault.
- `resp_superpage_o`  out  1  leaf found at level 1 (4 MiB page).
- `resp_page_fault_o`  out  1  Sv32 page fault.
- `resp_access_fault_o`  out  1  bus error during the walk.

## Operation
- FSM states: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP, DRAIN.
- IDLE: if any request is pending and `flush_i`=0, grant one requester. Priority is round-robin; `rr_q` is the last-served requester and the other one wins ties. Latch the vaddr and destination, then go to L1_REQ. A single request is granted regardless of `rr_q`.
- L1_REQ: `mem_req_o`=1, `mem_addr_o`={satp_ppn_i, vpn1, 2'b00}. Address is held stable until `mem_gnt_i`, then go to L1_WAIT.
- L1_WAIT, on `mem_rvalid_i`:
  - `mem_err_i` → access fault.
  - V=0, or (R=0 and W=1) → page fault.
  - Leaf (R|X) → superpage. Page fault if pte[19:10]≠0 (misaligned) or A=0. Otherwise success.
  - Non-leaf → latch pte[31:10] as the next PPN and go to L0_REQ.
- L0_REQ / L0_WAIT: address {pte_ppn_q, vpn0, 2'b00}. Same checks as level 1, except a non-leaf PTE is a page fault. Leaf with A=0 is a page fault.
- RESP: drive `resp_*` for exactly one cycle, update `rr_q`, then go to IDLE.
- A/D bits are never written by hardware. The D check belongs to the DTLB.
- Flush:
  - In L1_REQ or L0_REQ before `mem_gnt_i`: go to IDLE.
  - In L1_REQ or L0_REQ in the same cycle as `mem_gnt_i`: go to DRAIN.
  - In L1_WAIT or L0_WAIT: go to DRAIN. If `mem_rvalid_i` arrives in the flush cycle, go to IDLE instead.
  - In RESP: the response is suppressed.
  - DRAIN discards the next `mem_rvalid_i`, then goes to IDLE.
  - A flushed walk never produces a response, and `rr_q` is unchanged.
- `mem_rvalid_i` outside the WAIT and DRAIN states is ignored.

## Timing
- Reset values: state=IDLE, `rr_q`=DTLB (so ITLB wins the first tie). All outputs are 0: `*_gnt_o`, `mem_req_o`, `mem_addr_o`, all `resp_*`.
- Gnt is combinational in IDLE. The request must be held until gnt, and the vaddr is sampled on the gnt edge.
- The memory port allows one outstanding read. `rvalid` arrives at the earliest one cycle after the gnt handshake.
- Best-case latency from the gnt cycle (cycle 0), with zero-wait memory:
  - Superpage: `resp_valid_o` in cycle 3.
  - Two-level walk: `resp_valid_o` in cycle 5.
- No new grant is issued while the walker is busy or during the RESP cycle. The earliest next grant is the cycle after RESP.
- `resp_*` fields are registered and are valid only while `resp_valid_o`=1.

## Test plan
- Two-level walk, ITLB, satp_ppn=0x00100, vaddr=0x00401000:
  - Stimulus: L1 read at 0x00100004 returns 0x00080001; L0 read at 0x00200004 returns 0x000C004B.
  - Required: resp dst=0, vpn=0x00401, pte=0x000C004B, superpage=0, no faults, at cycle 5.
- Superpage, DTLB: L1 PTE 0x0010004B → superpage=1, pte=0x0010004B, cycle 3. L1 PTE 0x0000044B → page_fault=1, pte=0.
- Faults:
  - L1 PTE 0x00000000 → page fault.
  - L0 PTE non-leaf 0x00080001 → page fault.
  - `mem_err_i` on the L0 read → access_fault=1.
- Arbitration: ITLB and DTLB request together from reset → ITLB granted first, DTLB granted in the cycle after ITLB's RESP. Repeat with both requesters held → grants alternate I, D, I, D.
- Flush in L0_WAIT with a 3-cycle memory delay → DRAIN swallows the `rvalid`, no `resp_valid_o`, next request granted normally.
- Memory backpressure: `mem_gnt_i` low for 4 cycles → `mem_req_o` and `mem_addr_o` stable throughout. Async `rst_i` mid-walk → all outputs 0 immediately; a late `rvalid` is ignored.

Source files
------------

// File: rtl/sv32_ptw.sv
// Sv32 page-table walker shared by the ITLB and DTLB miss paths.
// Round-robin arbitration, one- or two-level walk over a single-outstanding read port.
module sv32_ptw #(
  parameter int VADDR_WD = 32,
  parameter int PADDR_WD = 34,
  parameter int PTE_WD   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [21:0]         satp_ppn_i,
  input  logic                flush_i,
  input  logic                itlb_req_i,
  input  logic [VADDR_WD-1:0] itlb_vaddr_i,
  output logic                itlb_gnt_o,
  input  logic                dtlb_req_i,
  input  logic [VADDR_WD-1:0] dtlb_vaddr_i,
  output logic                dtlb_gnt_o,
  output logic                mem_req_o,
  output logic [PADDR_WD-1:0] mem_addr_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [PTE_WD-1:0]   mem_rdata_i,
  input  logic                mem_err_i,
  output logic                resp_valid_o,
  output logic                resp_dst_o,
  output logic [19:0]         resp_vpn_o,
  output logic [PTE_WD-1:0]   resp_pte_o,
  output logic                resp_superpage_o,
  output logic                resp_page_fault_o,
  output logic                resp_access_fault_o
);

  typedef enum logic [2:0] {
    IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP, DRAIN
  } state_t;

  state_t              r_state;
  logic                r_rr;
  logic                r_dst;
  logic [19:0]         r_vpn;
  logic                r_mem_req;
  logic [PADDR_WD-1:0] r_mem_addr;
  logic                r_resp_valid;
  logic [PTE_WD-1:0]   r_resp_pte;
  logic                r_resp_sp;
  logic                r_resp_pf;
  logic                r_resp_af;

  logic                w_any_req;
  logic                w_pick_d;
  logic                w_grant;
  logic [VADDR_WD-1:0] w_vaddr;
  logic                w_l1;
  logic                w_v, w_r, w_w, w_x, w_a;
  logic                w_leaf;
  logic                w_invalid;
  logic                w_misaligned;
  logic                w_acc_fault;
  logic                w_pg_fault;
  logic                w_descend;
  logic                w_unused_ok;

  // Both requesting: the one not served last wins; otherwise whoever asks.
  assign w_any_req = itlb_req_i | dtlb_req_i;
  assign w_pick_d  = (itlb_req_i & dtlb_req_i) ? ~r_rr : dtlb_req_i;
  assign w_grant   = (r_state == IDLE) & ~flush_i & w_any_req & ~rst_i;
  assign w_vaddr   = w_pick_d ? dtlb_vaddr_i : itlb_vaddr_i;

  assign itlb_gnt_o = w_grant & ~w_pick_d;
  assign dtlb_gnt_o = w_grant &  w_pick_d;

  // Page offset bits play no part in the walk.
  assign w_unused_ok = ^{itlb_vaddr_i[11:0], dtlb_vaddr_i[11:0]};

  assign w_l1         = (r_state == L1_WAIT);
  assign w_v          = mem_rdata_i[0];
  assign w_r          = mem_rdata_i[1];
  assign w_w          = mem_rdata_i[2];
  assign w_x          = mem_rdata_i[3];
  assign w_a          = mem_rdata_i[6];
  assign w_leaf       = w_r | w_x;
  assign w_invalid    = ~w_v | (~w_r & w_w);
  assign w_misaligned = |mem_rdata_i[19:10];

  // A non-leaf PTE is only legal at level 1; superpage leaves must be aligned.
  assign w_acc_fault = mem_err_i;
  assign w_pg_fault  = ~w_acc_fault &
                       (w_invalid |
                        (w_leaf ? (~w_a | (w_l1 & w_misaligned)) : ~w_l1));
  assign w_descend   = w_l1 & ~w_acc_fault & ~w_invalid & ~w_leaf;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_rr         <= 1'b1;
      r_dst        <= 1'b0;
      r_vpn        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_pte   <= '0;
      r_resp_sp    <= 1'b0;
      r_resp_pf    <= 1'b0;
      r_resp_af    <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_dst      <= w_pick_d;
            r_vpn      <= w_vaddr[31:12];
            r_mem_req  <= 1'b1;
            r_mem_addr <= {satp_ppn_i, w_vaddr[31:22], 2'b00};
            r_state    <= L1_REQ;
          end
        end
        L1_REQ, L0_REQ: begin
          if (mem_gnt_i) begin
            r_mem_req <= 1'b0;
            if (flush_i)
              r_state <= DRAIN;
            else if (r_state == L1_REQ)
              r_state <= L1_WAIT;
            else
              r_state <= L0_WAIT;
          end else if (flush_i) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        L1_WAIT, L0_WAIT: begin
          if (mem_rvalid_i) begin
            if (flush_i) begin
              r_state <= IDLE;
            end else if (w_descend) begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= {mem_rdata_i[31:10], r_vpn[9:0], 2'b00};
              r_state    <= L0_REQ;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_pte   <= (w_acc_fault | w_pg_fault) ? '0 : mem_rdata_i;
              r_resp_sp    <= w_l1 & ~w_acc_fault & ~w_pg_fault;
              r_resp_pf    <= w_pg_fault;
              r_resp_af    <= w_acc_fault;
              r_state      <= RESP;
            end
          end else if (flush_i) begin
            r_state <= DRAIN;
          end
        end
        RESP: begin
          if (!flush_i)
            r_rr <= r_dst;
          r_state <= IDLE;
        end
        DRAIN: begin
          if (mem_rvalid_i)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req_o           = r_mem_req;
  assign mem_addr_o          = r_mem_addr;
  // A flush landing on the response cycle cancels the response.
  assign resp_valid_o        = r_resp_valid & ~flush_i;
  assign resp_dst_o          = r_dst;
  assign resp_vpn_o          = r_vpn;
  assign resp_pte_o          = r_resp_pte;
  assign resp_superpage_o    = r_resp_sp;
  assign resp_page_fault_o   = r_resp_pf;
  assign resp_access_fault_o = r_resp_af;

endmodule

// File: tb/tb_sv32_ptw.sv
// Directed bench for sv32_ptw: scripted page-table memory, response/grant monitor,
// hand-computed expectations for walks, faults, arbitration, flush and reset.
module tb_sv32_ptw;

  logic        clk;
  logic        rst_i;
  logic [21:0] satp_ppn_i;
  logic        flush_i;
  logic        itlb_req_i;
  logic [31:0] itlb_vaddr_i;
  logic        itlb_gnt_o;
  logic        dtlb_req_i;
  logic [31:0] dtlb_vaddr_i;
  logic        dtlb_gnt_o;
  logic        mem_req_o;
  logic [33:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        resp_valid_o;
  logic        resp_dst_o;
  logic [19:0] resp_vpn_o;
  logic [31:0] resp_pte_o;
  logic        resp_superpage_o;
  logic        resp_page_fault_o;
  logic        resp_access_fault_o;

  sv32_ptw dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .satp_ppn_i          (satp_ppn_i),
    .flush_i             (flush_i),
    .itlb_req_i          (itlb_req_i),
    .itlb_vaddr_i        (itlb_vaddr_i),
    .itlb_gnt_o          (itlb_gnt_o),
    .dtlb_req_i          (dtlb_req_i),
    .dtlb_vaddr_i        (dtlb_vaddr_i),
    .dtlb_gnt_o          (dtlb_gnt_o),
    .mem_req_o           (mem_req_o),
    .mem_addr_o          (mem_addr_o),
    .mem_gnt_i           (mem_gnt_i),
    .mem_rvalid_i        (mem_rvalid_i),
    .mem_rdata_i         (mem_rdata_i),
    .mem_err_i           (mem_err_i),
    .resp_valid_o        (resp_valid_o),
    .resp_dst_o          (resp_dst_o),
    .resp_vpn_o          (resp_vpn_o),
    .resp_pte_o          (resp_pte_o),
    .resp_superpage_o    (resp_superpage_o),
    .resp_page_fault_o   (resp_page_fault_o),
    .resp_access_fault_o (resp_access_fault_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Page-table contents used by all walks; satp_ppn = 0x00100.
  function automatic logic [31:0] lookup(input logic [33:0] a);
    case (a)
      34'h00100004: return 32'h00080001;
      34'h00200004: return 32'h000C004B;
      34'h0010000C: return 32'h0010004B;
      34'h00100010: return 32'h0000044B;
      34'h00100014: return 32'h00000000;
      34'h00100018: return 32'h00080001;
      34'h00200008: return 32'h00080001;
      34'h0010001C: return 32'h00080001;
      default:      return 32'h00000000;
    endcase
  endfunction

  localparam logic [33:0] ERR_ADDR = 34'h0020000C;

  // Memory model: gnt after gntDelay cycles of req, rvalid rspDelay cycles after the earliest slot.
  int          gntDelay = 0;
  int          rspDelay = 0;
  int          mPhase   = 0;
  int          mCnt     = 0;
  logic [33:0] mAddr;
  int          memAddrN = 0;
  logic [33:0] memAddrLog[64];

  initial begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    mem_err_i    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      mem_err_i    = 1'b0;
      if (mPhase == 2) begin
        if (mCnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = lookup(mAddr);
          mem_err_i    = (mAddr == ERR_ADDR);
          mPhase       = 0;
        end else begin
          mCnt--;
        end
      end else if (mPhase == 1 && !mem_req_o) begin
        mPhase = 0;
      end
      if (mPhase == 0 && mem_req_o && !rst_i) begin
        mPhase = 1;
        mCnt   = gntDelay;
      end
      if (mPhase == 1) begin
        if (mCnt == 0) begin
          mem_gnt_i = 1'b1;
          mAddr     = mem_addr_o;
          if (memAddrN < 64) memAddrLog[memAddrN] = mem_addr_o;
          memAddrN++;
          mPhase = 2;
          mCnt   = rspDelay;
        end else begin
          mCnt--;
        end
      end
    end
  end

  // Monitor: log every grant and response with its cycle number.
  int          gntN = 0;
  int          respN = 0;
  logic        gDst[64];
  int          gCyc[64];
  logic        rDst[64];
  logic [19:0] rVpn[64];
  logic [31:0] rPte[64];
  logic        rSp[64];
  logic        rPf[64];
  logic        rAf[64];
  int          rCyc[64];

  always @(negedge clk) begin
    if (itlb_gnt_o || dtlb_gnt_o) begin
      if (gntN < 64) begin
        gDst[gntN] = dtlb_gnt_o;
        gCyc[gntN] = cyc;
      end
      gntN++;
    end
    if (resp_valid_o) begin
      if (respN < 64) begin
        rDst[respN] = resp_dst_o;
        rVpn[respN] = resp_vpn_o;
        rPte[respN] = resp_pte_o;
        rSp[respN]  = resp_superpage_o;
        rPf[respN]  = resp_page_fault_o;
        rAf[respN]  = resp_access_fault_o;
        rCyc[respN] = cyc;
      end
      respN++;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Raise one requester, hold until its grant, drop it the cycle after.
  task automatic applyStimulus(input logic dst, input logic [31:0] va);
    bit got = 0;
    @(posedge clk);
    #1;
    if (dst) begin dtlb_req_i = 1'b1; dtlb_vaddr_i = va; end
    else     begin itlb_req_i = 1'b1; itlb_vaddr_i = va; end
    for (int i = 0; i < 100; i++) begin
      #1;
      if ((dst && dtlb_gnt_o) || (!dst && itlb_gnt_o)) begin
        got = 1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    itlb_req_i = 1'b0;
    dtlb_req_i = 1'b0;
    checkOutput("grant_seen", 64'(got), 64'd1);
  endtask

  // Hold both requesters until n grants have been issued in total.
  task automatic runBoth(input int n);
    int cnt = 0;
    @(posedge clk);
    #1;
    itlb_req_i = 1'b1;
    dtlb_req_i = 1'b1;
    for (int i = 0; i < 200 && cnt < n; i++) begin
      #1;
      if (itlb_gnt_o || dtlb_gnt_o) cnt++;
      @(posedge clk);
      #1;
    end
    itlb_req_i = 1'b0;
    dtlb_req_i = 1'b0;
    checkOutput("both_grants", 64'(cnt), 64'(n));
  endtask

  task automatic waitResp(input int target);
    for (int i = 0; i < 200 && respN < target; i++) @(negedge clk);
    @(negedge clk);
    checkOutput("resp_count", 64'(respN), 64'(target));
  endtask

  task automatic checkResp(input string tag, input int idx, input logic dst, input logic [19:0] vpn,
                           input logic [31:0] pte, input logic sp, input logic pf, input logic af);
    checkOutput({tag, "_dst"}, 64'(rDst[idx]), 64'(dst));
    checkOutput({tag, "_vpn"}, 64'(rVpn[idx]), 64'(vpn));
    checkOutput({tag, "_pte"}, 64'(rPte[idx]), 64'(pte));
    checkOutput({tag, "_sp"},  64'(rSp[idx]),  64'(sp));
    checkOutput({tag, "_pf"},  64'(rPf[idx]),  64'(pf));
    checkOutput({tag, "_af"},  64'(rAf[idx]),  64'(af));
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_itlb_gnt"}, 64'(itlb_gnt_o), 64'd0);
    checkOutput({tag, "_dtlb_gnt"}, 64'(dtlb_gnt_o), 64'd0);
    checkOutput({tag, "_mem_req"},  64'(mem_req_o),  64'd0);
    checkOutput({tag, "_mem_addr"}, 64'(mem_addr_o), 64'd0);
    checkOutput({tag, "_resp_v"},   64'(resp_valid_o), 64'd0);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #3;
    rst_i = 1'b1;
    @(posedge clk);
    #3;
    rst_i = 1'b0;
  endtask

  int gb, rb, mb;

  initial begin
    rst_i        = 1'b1;
    satp_ppn_i   = 22'h00100;
    flush_i      = 1'b0;
    itlb_req_i   = 1'b1;
    itlb_vaddr_i = 32'h0;
    dtlb_req_i   = 1'b1;
    dtlb_vaddr_i = 32'h0;

    // Reset state, with requests pending to show grants are held off.
    #12;
    checkIdleOutputs("reset");
    itlb_req_i = 1'b0;
    dtlb_req_i = 1'b0;
    #11;
    rst_i = 1'b0;

    // Two-level ITLB walk.
    gb = gntN; rb = respN; mb = memAddrN;
    applyStimulus(1'b0, 32'h00401000);
    waitResp(rb + 1);
    checkResp("walk2", rb, 1'b0, 20'h00401, 32'h000C004B, 1'b0, 1'b0, 1'b0);
    checkOutput("walk2_lat", 64'(rCyc[rb] - gCyc[gb]), 64'd5);
    checkOutput("walk2_l1addr", 64'(memAddrLog[mb]), 64'h00100004);
    checkOutput("walk2_l0addr", 64'(memAddrLog[mb+1]), 64'h00200004);

    // DTLB superpage, aligned.
    gb = gntN; rb = respN;
    applyStimulus(1'b1, 32'h00C00000);
    waitResp(rb + 1);
    checkResp("super", rb, 1'b1, 20'h00C00, 32'h0010004B, 1'b1, 1'b0, 1'b0);
    checkOutput("super_lat", 64'(rCyc[rb] - gCyc[gb]), 64'd3);

    // DTLB superpage, misaligned PPN0.
    rb = respN;
    applyStimulus(1'b1, 32'h01000000);
    waitResp(rb + 1);
    checkResp("misal", rb, 1'b1, 20'h01000, 32'h0, 1'b0, 1'b1, 1'b0);

    // Invalid L1 PTE.
    rb = respN;
    applyStimulus(1'b0, 32'h01400000);
    waitResp(rb + 1);
    checkResp("inval", rb, 1'b0, 20'h01400, 32'h0, 1'b0, 1'b1, 1'b0);

    // Non-leaf at level 0.
    rb = respN;
    applyStimulus(1'b0, 32'h01802000);
    waitResp(rb + 1);
    checkResp("l0nl", rb, 1'b0, 20'h01802, 32'h0, 1'b0, 1'b1, 1'b0);

    // Bus error on the level-0 read.
    rb = respN;
    applyStimulus(1'b1, 32'h01C03000);
    waitResp(rb + 1);
    checkResp("accf", rb, 1'b1, 20'h01C03, 32'h0, 1'b0, 1'b0, 1'b1);

    // Arbitration from reset: I, D, I, D with both held.
    pulseReset();
    itlb_vaddr_i = 32'h00C00000;
    dtlb_vaddr_i = 32'h00C00000;
    gb = gntN; rb = respN;
    runBoth(4);
    waitResp(rb + 4);
    checkOutput("arb_g0", 64'(gDst[gb]),   64'd0);
    checkOutput("arb_g1", 64'(gDst[gb+1]), 64'd1);
    checkOutput("arb_g2", 64'(gDst[gb+2]), 64'd0);
    checkOutput("arb_g3", 64'(gDst[gb+3]), 64'd1);
    checkOutput("arb_next", 64'(gCyc[gb+1]), 64'(rCyc[rb] + 1));
    checkResp("arb_r1", rb + 1, 1'b1, 20'h00C00, 32'h0010004B, 1'b1, 1'b0, 1'b0);

    // Flush in L0_WAIT with slow memory; DRAIN swallows the data.
    rspDelay = 3;
    rb = respN; mb = memAddrN;
    applyStimulus(1'b0, 32'h00401000);
    for (int i = 0; i < 100 && memAddrN < mb + 2; i++) begin
      @(posedge clk);
      #2;
    end
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    checkOutput("flush_noresp", 64'(respN), 64'(rb));
    checkOutput("flush_noreq",  64'(mem_req_o), 64'd0);
    rspDelay = 0;
    itlb_vaddr_i = 32'h00C00000;
    dtlb_vaddr_i = 32'h00C00000;
    gb = gntN;
    runBoth(2);
    waitResp(rb + 2);
    checkOutput("flush_rr_keep", 64'(gDst[gb]), 64'd0);
    checkResp("after_flush", rb, 1'b0, 20'h00C00, 32'h0010004B, 1'b1, 1'b0, 1'b0);

    // Memory backpressure: request and address stay put.
    gntDelay = 4;
    gb = gntN; rb = respN;
    applyStimulus(1'b0, 32'h00C00000);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("bp_req",  64'(mem_req_o),  64'd1);
      checkOutput("bp_addr", 64'(mem_addr_o), 64'h0010000C);
      @(posedge clk);
      #1;
    end
    gntDelay = 0;
    waitResp(rb + 1);
    checkOutput("bp_lat", 64'(rCyc[rb] - gCyc[gb]), 64'd7);
    checkOutput("bp_pte", 64'(rPte[rb]), 64'h0010004B);

    // Async reset in L0_WAIT; the late rvalid must not produce anything.
    rspDelay = 3;
    rb = respN; mb = memAddrN;
    applyStimulus(1'b0, 32'h00401000);
    for (int i = 0; i < 100 && memAddrN < mb + 2; i++) begin
      @(posedge clk);
      #2;
    end
    @(posedge clk);
    #3;
    rst_i = 1'b1;
    #1;
    checkIdleOutputs("midrst");
    @(posedge clk);
    #3;
    rst_i = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    checkOutput("midrst_noresp", 64'(respN), 64'(rb));
    checkOutput("midrst_noread", 64'(memAddrN), 64'(mb + 2));
    rspDelay = 0;
    applyStimulus(1'b1, 32'h00C00000);
    waitResp(rb + 1);
    checkResp("post_rst", rb, 1'b1, 20'h00C00, 32'h0010004B, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
